fma_issue_ctrl: RTL and testbench
=================================

FMA_ISSUE_CTRL -- requirements
Module: fma_issue_ctrl

Interface
REQ-001 SHALL have parameter PARM_RM, default 3, meaning rounding-mode field width.
REQ-002 SHALL have parameter PARM_TAG, default 4, meaning requester tag width.
REQ-003 SHALL have parameter PARM_STAGES, default 3, meaning FMA pipeline depth; the last stage is NormandRound. Legal range is 2..8.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state is rising-edge.
REQ-005 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have ports Req0_valid_i and Req1_valid_i, inputs, 1 bit each, requester issue strobes.
REQ-007 SHALL have ports Req0_ready_o and Req1_ready_o, outputs, 1 bit each, grant/accept for each requester.
REQ-008 SHALL have ports Req0_tag_i and Req1_tag_i, inputs, PARM_TAG bits each, operation tags.
REQ-009 SHALL have ports Req0_rm_i and Req1_rm_i, inputs, PARM_RM bits each, instruction rm field.
REQ-010 SHALL have port Frm_i, input, PARM_RM bits, fcsr.frm dynamic rounding mode.
REQ-011 SHALL have port Stage_en_o, output, PARM_STAGES bits, per-stage datapath register enable.
REQ-012 SHALL have port Src_sel_o, output, 1 bit, operand mux select for stage 0 (0 = Req0, 1 = Req1).
REQ-013 SHALL have port Rounding_mode_o, output, PARM_RM bits, resolved rm of the op in the last stage.
REQ-014 SHALL have port Flags_i, input, 4 bits, {Invalid, Overflow, Underflow, Inexact} from NormandRound.
REQ-015 SHALL have ports Resp_valid_o (output, 1 bit) and Resp_ready_i (input, 1 bit), the result handshake.
REQ-016 SHALL have ports Resp_tag_o (output, PARM_TAG bits) and Resp_illegal_o (output, 1 bit), the result tag and illegal-rm indication.
REQ-017 SHALL have ports Fflags_o (output, 4 bits, sticky accrued flags) and Fflags_clr_i (input, 1 bit, sticky clear).
REQ-018 SHALL have port Busy_o, output, 1 bit, asserted when any stage holds a valid op.

Function
REQ-019 SHALL keep a valid bit, tag, resolved rm and illegal bit per stage.
REQ-020 SHALL advance the last stage when it is empty or when Resp_valid_o && Resp_ready_i.
REQ-021 SHALL advance stage k when it is empty or when stage k+1 advances.
REQ-022 SHALL drive Stage_en_o[k] to equal the advance condition of stage k.
REQ-023 SHALL assert at most one ReqN_ready_o per cycle, only when stage 0 advances and ReqN_valid_i is 1.
REQ-024 SHALL resolve rm as follows: rm=3'b111 takes Frm_i; a resolved value of 3'b101, 3'b110 or 3'b111 is illegal.
REQ-025 SHALL accept an illegal op and carry it with illegal=1; Resp_illegal_o SHALL be 1 and its flags SHALL be ignored.
REQ-026 SHALL, with no stall, present Resp_valid_o exactly PARM_STAGES cycles after acceptance, with back-to-back issue at 1 op/cycle.
REQ-027 SHALL hold Resp_valid_o, Resp_tag_o, Resp_illegal_o and Rounding_mode_o stable while Resp_ready_i=0.
REQ-028 SHALL, on a legal response handshake, update Fflags_o <= Fflags_o | Flags_i.
REQ-029 SHALL, when Fflags_clr_i and a handshake coincide, compute Fflags_o <= Flags_i (clear applies first, new flags are kept).
REQ-030 SHALL preserve order: responses leave in acceptance order, and tags are not reordered.
REQ-031 SHALL drive Src_sel_o to the granted requester, and hold its previous value when there is no grant.

Reset
REQ-032 SHALL, on rst_i assertion, clear all stage valid bits, Fflags_o, Busy_o, Resp_valid_o, ReqN_ready_o and Stage_en_o immediately, without waiting for a clock edge.
REQ-033 SHALL reset the arbiter pointer to Req0 priority and Src_sel_o to 0; in-flight ops are discarded with no response.

Configuration
REQ-034 SHALL, with FMA_RR_ARB_EN defined, use round-robin arbitration: priority toggles to the other requester after each grant.
REQ-035 SHALL, without FMA_RR_ARB_EN, use fixed priority with Req0 always first; the pointer register SHALL be absent.

Verification
REQ-036 SHALL check: Req0 tag 5, rm 000, issued at cycle 10 with Resp_ready_i=1 -> Resp_valid_o=1, Resp_tag_o=5 at cycle 10+PARM_STAGES (13).
REQ-037 SHALL check: both requesters valid for 4 cycles with FMA_RR_ARB_EN -> grants 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-038 SHALL check: Resp_ready_i=0 for 5 cycles with 4 ops issued -> at most PARM_STAGES accepted, outputs stable, then 4 in-order responses.
REQ-039 SHALL check: rm 111 with Frm_i=110 -> Resp_illegal_o=1 and Fflags_o unchanged; rm 111 with Frm_i=001 -> Rounding_mode_o=001.
REQ-040 SHALL check: Flags_i=0001 then 1000 on two handshakes -> Fflags_o=1001; Fflags_clr_i with Flags_i=0100 at a handshake -> Fflags_o=0100.
REQ-041 SHALL check: rst_i asserted mid-flight with 2 ops in the pipe -> Busy_o=0 and Resp_valid_o=0 asynchronously, and no response is emitted afterwards.

Source files
------------

// File: rtl/fma_issue_ctrl.sv
// Issue/retire controller for a PARM_STAGES-deep FMA pipeline with two
// requesters, rounding-mode resolution, sticky fflags and response handshake.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   Req{0,1}_valid/ready     requester issue handshakes
//   Req{0,1}_tag_i/_rm_i     per-request tag and instruction rm field
//   Frm_i                    dynamic rounding mode (fcsr.frm)
//   Stage_en_o               per-stage datapath register enables
//   Src_sel_o                stage-0 operand mux select (0 = Req0, 1 = Req1)
//   Rounding_mode_o          resolved rm of the op in the last stage
//   Flags_i                  {NV, OF, UF, NX} from the last stage
//   Resp_valid/ready/tag/illegal  result handshake
//   Fflags_o, Fflags_clr_i   sticky accrued flags and clear
//   Busy_o                   any stage occupied
//
// Optional build macro FMA_RR_ARB_EN: round-robin arbitration between the two
// requesters. Without it, Req0 has fixed priority.

module fma_issue_ctrl #(
    parameter int PARM_RM     = 3,
    parameter int PARM_TAG    = 4,
    parameter int PARM_STAGES = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   Req0_valid_i,
    input  logic                   Req1_valid_i,
    output logic                   Req0_ready_o,
    output logic                   Req1_ready_o,
    input  logic [PARM_TAG-1:0]    Req0_tag_i,
    input  logic [PARM_TAG-1:0]    Req1_tag_i,
    input  logic [PARM_RM-1:0]     Req0_rm_i,
    input  logic [PARM_RM-1:0]     Req1_rm_i,
    input  logic [PARM_RM-1:0]     Frm_i,
    output logic [PARM_STAGES-1:0] Stage_en_o,
    output logic                   Src_sel_o,
    output logic [PARM_RM-1:0]     Rounding_mode_o,
    input  logic [3:0]             Flags_i,
    output logic                   Resp_valid_o,
    input  logic                   Resp_ready_i,
    output logic [PARM_TAG-1:0]    Resp_tag_o,
    output logic                   Resp_illegal_o,
    output logic [3:0]             Fflags_o,
    input  logic                   Fflags_clr_i,
    output logic                   Busy_o
);

    localparam int S = PARM_STAGES;
    localparam logic [PARM_RM-1:0] RM_DYN = PARM_RM'(7);
    localparam logic [PARM_RM-1:0] RM_R5  = PARM_RM'(5);
    localparam logic [PARM_RM-1:0] RM_R6  = PARM_RM'(6);

    logic [S-1:0]        vld_q;
    logic [S-1:0]        ill_q;
    logic [PARM_TAG-1:0] tag_q [S];
    logic [PARM_RM-1:0]  rm_q  [S];
    logic [S-1:0]        adv;
    logic                full_run;
    logic [3:0]          fflags_q;
    logic                sel_q;
    logic                pick1;
    logic                can_issue;
    logic                gnt0;
    logic                gnt1;
    logic [PARM_TAG-1:0] in_tag;
    logic [PARM_RM-1:0]  raw_rm;
    logic [PARM_RM-1:0]  res_rm;
    logic                in_ill;
    logic                resp_hs;

    // Stage k moves when the response is taken or any stage from k down to
    // the last one has a hole: bubbles collapse toward the output.
    always_comb begin
        adv      = '0;
        full_run = 1'b1;
        for (int k = S - 1; k >= 0; k--) begin
            full_run = full_run & vld_q[k];
            adv[k]   = Resp_ready_i | ~full_run;
        end
    end

`ifdef FMA_RR_ARB_EN
    // ptr_q = 1 gives Req1 priority; flips away from whoever was granted.
    logic ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ptr_q <= 1'b0;
        else if (gnt0 | gnt1)
            ptr_q <= gnt0;
    end

    assign pick1 = Req1_valid_i & (~Req0_valid_i | ptr_q);
`else
    assign pick1 = Req1_valid_i & ~Req0_valid_i;
`endif

    assign can_issue = adv[0] & ~rst_i;
    assign gnt0      = can_issue & Req0_valid_i & ~pick1;
    assign gnt1      = can_issue & pick1;

    always_comb begin
        in_tag = pick1 ? Req1_tag_i : Req0_tag_i;
        raw_rm = pick1 ? Req1_rm_i : Req0_rm_i;
        res_rm = (raw_rm == RM_DYN) ? Frm_i : raw_rm;
        in_ill = (res_rm == RM_R5) | (res_rm == RM_R6) | (res_rm == RM_DYN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            ill_q <= '0;
            for (int k = 0; k < S; k++) begin
                tag_q[k] <= '0;
                rm_q[k]  <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld_q[0] <= gnt0 | gnt1;
                ill_q[0] <= in_ill;
                tag_q[0] <= in_tag;
                rm_q[0]  <= res_rm;
            end
            for (int k = 1; k < S; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    ill_q[k] <= ill_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                    rm_q[k]  <= rm_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sel_q <= 1'b0;
        else if (gnt0 | gnt1)
            sel_q <= gnt1;
    end

    assign resp_hs = vld_q[S-1] & Resp_ready_i;

    // Clear takes effect before this cycle's flags are merged in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            fflags_q <= '0;
        else if (Fflags_clr_i)
            fflags_q <= (resp_hs & ~ill_q[S-1]) ? Flags_i : 4'b0000;
        else if (resp_hs & ~ill_q[S-1])
            fflags_q <= fflags_q | Flags_i;
    end

    assign Req0_ready_o    = gnt0;
    assign Req1_ready_o    = gnt1;
    assign Src_sel_o       = (gnt0 | gnt1) ? gnt1 : sel_q;
    assign Stage_en_o      = rst_i ? '0 : adv;
    assign Resp_valid_o    = vld_q[S-1];
    assign Resp_tag_o      = tag_q[S-1];
    assign Resp_illegal_o  = ill_q[S-1];
    assign Rounding_mode_o = rm_q[S-1];
    assign Fflags_o        = fflags_q;
    assign Busy_o          = |vld_q;

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Self-checking bench for fma_issue_ctrl: directed scenarios plus a
// randomized run against a queue-based capacity/order model.

module tb_fma_issue_ctrl;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       Req0_valid_i = 1'b0;
    logic       Req1_valid_i = 1'b0;
    logic       Req0_ready_o;
    logic       Req1_ready_o;
    logic [3:0] Req0_tag_i = '0;
    logic [3:0] Req1_tag_i = '0;
    logic [2:0] Req0_rm_i = '0;
    logic [2:0] Req1_rm_i = '0;
    logic [2:0] Frm_i = '0;
    logic [S-1:0] Stage_en_o;
    logic       Src_sel_o;
    logic [2:0] Rounding_mode_o;
    logic [3:0] Flags_i = '0;
    logic       Resp_valid_o;
    logic       Resp_ready_i = 1'b0;
    logic [3:0] Resp_tag_o;
    logic       Resp_illegal_o;
    logic [3:0] Fflags_o;
    logic       Fflags_clr_i = 1'b0;
    logic       Busy_o;

    int cyc = 0;
    int vectors = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] tag;
        logic [2:0] rm;
        logic       ill;
    } op_t;

    typedef struct {
        int         due;
        logic [3:0] tag;
    } exp_t;

    fma_issue_ctrl #(
        .PARM_RM(3),
        .PARM_TAG(4),
        .PARM_STAGES(S)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .Req0_valid_i(Req0_valid_i),
        .Req1_valid_i(Req1_valid_i),
        .Req0_ready_o(Req0_ready_o),
        .Req1_ready_o(Req1_ready_o),
        .Req0_tag_i(Req0_tag_i),
        .Req1_tag_i(Req1_tag_i),
        .Req0_rm_i(Req0_rm_i),
        .Req1_rm_i(Req1_rm_i),
        .Frm_i(Frm_i),
        .Stage_en_o(Stage_en_o),
        .Src_sel_o(Src_sel_o),
        .Rounding_mode_o(Rounding_mode_o),
        .Flags_i(Flags_i),
        .Resp_valid_o(Resp_valid_o),
        .Resp_ready_i(Resp_ready_i),
        .Resp_tag_o(Resp_tag_o),
        .Resp_illegal_o(Resp_illegal_o),
        .Fflags_o(Fflags_o),
        .Fflags_clr_i(Fflags_clr_i),
        .Busy_o(Busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Req0_valid_i = 1'b0;
        Req1_valid_i = 1'b0;
        Flags_i      = '0;
        Fflags_clr_i = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        #2;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        Req0_valid_i = 1'b1;
        Req1_valid_i = 1'b1;
        Resp_ready_i = 1'b1;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({Busy_o, Resp_valid_o, Req0_ready_o, Req1_ready_o} !== 4'b0000)
            $display("FAIL reset_ctl got=%b want=0000",
                     {Busy_o, Resp_valid_o, Req0_ready_o, Req1_ready_o});
        if ({Busy_o, Resp_valid_o, Req0_ready_o, Req1_ready_o} !== 4'b0000)
            errors++;
        vectors++;
        if (Stage_en_o !== '0 || Fflags_o !== 4'b0 || Src_sel_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state en=%b ff=%b sel=%b want 0",
                     Stage_en_o, Fflags_o, Src_sel_o);
        end
        tick();
        tick();
        rst_i = 1'b0;
        idle_inputs();
    endtask

    task automatic test_latency();
        int acc;
        logic exp;
        while (cyc < 10) tick();
        Resp_ready_i = 1'b1;
        Req0_valid_i = 1'b1;
        Req0_tag_i   = 4'd5;
        Req0_rm_i    = 3'b000;
        @(negedge clk);
        acc = cyc;
        vectors++;
        if (Req0_ready_o !== 1'b1 || acc != 10) begin
            errors++;
            $display("FAIL lat_accept ready=%b cyc=%0d want 1 at 10",
                     Req0_ready_o, acc);
        end
        tick();
        Req0_valid_i = 1'b0;
        for (int i = 1; i <= S + 1; i++) begin
            @(negedge clk);
            exp = (cyc == acc + S);
            vectors++;
            if (Resp_valid_o !== exp) begin
                errors++;
                $display("FAIL lat_valid cyc=%0d got=%b want=%b",
                         cyc, Resp_valid_o, exp);
            end
            if (exp) begin
                vectors++;
                if (Resp_tag_o !== 4'd5 || Rounding_mode_o !== 3'b000 ||
                    Resp_illegal_o !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_resp tag=%0d rm=%b ill=%b want 5/000/0",
                             Resp_tag_o, Rounding_mode_o, Resp_illegal_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_arb();
        int exp;
        apply_reset();
        Resp_ready_i = 1'b1;
        Req0_valid_i = 1'b1;
        Req1_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Req0_tag_i = 4'(i);
            Req1_tag_i = 4'(8 + i);
`ifdef FMA_RR_ARB_EN
            exp = i % 2;
`else
            exp = 0;
`endif
            @(negedge clk);
            vectors++;
            if (Req0_ready_o !== (exp == 0) || Req1_ready_o !== (exp == 1) ||
                Src_sel_o !== 1'(exp)) begin
                errors++;
                $display("FAIL arb_grant i=%0d r0=%b r1=%b sel=%b want grant %0d",
                         i, Req0_ready_o, Req1_ready_o, Src_sel_o, exp);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (Src_sel_o !== 1'(exp)) begin
            errors++;
            $display("FAIL arb_hold sel=%b want=%0d", Src_sel_o, exp);
        end
        for (int i = 0; i < S + 2; i++) tick();
    endtask

    task automatic test_stall();
        int nacc = 0;
        int nresp = 0;
        int budget = 0;
        logic seen = 1'b0;
        logic [3:0] cap_tag;
        logic [2:0] cap_rm;
        logic cap_ill;
        apply_reset();
        Resp_ready_i = 1'b0;
        Req0_rm_i = 3'b010;
        for (int i = 0; i < 5; i++) begin
            Req0_valid_i = (nacc < 4);
            Req0_tag_i   = 4'(nacc + 1);
            @(negedge clk);
            if (Req0_ready_o) nacc++;
            if (seen) begin
                vectors++;
                if (Resp_valid_o !== 1'b1 || Resp_tag_o !== cap_tag ||
                    Rounding_mode_o !== cap_rm || Resp_illegal_o !== cap_ill) begin
                    errors++;
                    $display("FAIL stall_stable v=%b tag=%0d rm=%b ill=%b",
                             Resp_valid_o, Resp_tag_o, Rounding_mode_o,
                             Resp_illegal_o);
                end
            end else if (Resp_valid_o) begin
                seen    = 1'b1;
                cap_tag = Resp_tag_o;
                cap_rm  = Rounding_mode_o;
                cap_ill = Resp_illegal_o;
            end
            tick();
        end
        vectors++;
        if (nacc != S) begin
            errors++;
            $display("FAIL stall_accepted got=%0d want=%0d", nacc, S);
        end
        Resp_ready_i = 1'b1;
        while (nresp < 4 && budget < 20) begin
            Req0_valid_i = (nacc < 4);
            Req0_tag_i   = 4'(nacc + 1);
            @(negedge clk);
            if (Resp_valid_o) begin
                vectors++;
                if (Resp_tag_o !== 4'(nresp + 1)) begin
                    errors++;
                    $display("FAIL stall_order got=%0d want=%0d",
                             Resp_tag_o, nresp + 1);
                end
                nresp++;
            end
            if (Req0_ready_o) nacc++;
            tick();
            budget++;
        end
        idle_inputs();
        vectors++;
        if (nresp != 4) begin
            errors++;
            $display("FAIL stall_drain got=%0d responses want=4", nresp);
        end
    endtask

    task automatic test_rm();
        logic [2:0] frm_tab [2];
        logic [2:0] rm_exp  [2];
        logic       ill_exp [2];
        int budget;
        logic got;
        frm_tab[0] = 3'b110; rm_exp[0] = 3'b110; ill_exp[0] = 1'b1;
        frm_tab[1] = 3'b001; rm_exp[1] = 3'b001; ill_exp[1] = 1'b0;
        apply_reset();
        Resp_ready_i = 1'b1;
        for (int n = 0; n < 2; n++) begin
            Req1_valid_i = 1'b1;
            Req1_tag_i   = 4'(3 + n);
            Req1_rm_i    = 3'b111;
            Frm_i        = frm_tab[n];
            Flags_i      = (n == 0) ? 4'b1111 : 4'b0000;
            tick();
            Req1_valid_i = 1'b0;
            Frm_i = 3'b000;
            budget = 0;
            got = 1'b0;
            while (!got && budget < S + 3) begin
                @(negedge clk);
                if (Resp_valid_o) begin
                    got = 1'b1;
                    vectors++;
                    if (Resp_illegal_o !== ill_exp[n] ||
                        Rounding_mode_o !== rm_exp[n]) begin
                        errors++;
                        $display("FAIL rm_resolve n=%0d ill=%b rm=%b want %b/%b",
                                 n, Resp_illegal_o, Rounding_mode_o,
                                 ill_exp[n], rm_exp[n]);
                    end
                end
                tick();
                budget++;
            end
            vectors++;
            if (!got || Fflags_o !== 4'b0000) begin
                errors++;
                $display("FAIL rm_flags n=%0d got_resp=%b ff=%b want 1/0000",
                         n, got, Fflags_o);
            end
        end
        idle_inputs();
    endtask

    task automatic test_flags();
        logic [3:0] ftab [3];
        logic [3:0] fexp [3];
        int n = 0;
        int budget = 0;
        logic hs;
        ftab[0] = 4'b0001; fexp[0] = 4'b0001;
        ftab[1] = 4'b1000; fexp[1] = 4'b1001;
        ftab[2] = 4'b0100; fexp[2] = 4'b0100;
        apply_reset();
        Resp_ready_i = 1'b1;
        Req0_rm_i = 3'b000;
        for (int i = 0; i < 3; i++) begin
            Req0_valid_i = 1'b1;
            Req0_tag_i = 4'(i);
            tick();
        end
        Req0_valid_i = 1'b0;
        while (n < 3 && budget < 12) begin
            @(negedge clk);
            hs = Resp_valid_o;
            if (hs) begin
                Flags_i = ftab[n];
                Fflags_clr_i = (n == 2);
            end
            tick();
            Flags_i = '0;
            Fflags_clr_i = 1'b0;
            if (hs) begin
                vectors++;
                if (Fflags_o !== fexp[n]) begin
                    errors++;
                    $display("FAIL flags_accrue n=%0d got=%b want=%b",
                             n, Fflags_o, fexp[n]);
                end
                n++;
            end
            budget++;
        end
        vectors++;
        if (n != 3) begin
            errors++;
            $display("FAIL flags_resp got=%0d want=3", n);
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        logic want;
        Resp_ready_i = 1'b1;
        for (int i = 0; i < 8 + S + 2; i++) begin
            Req1_valid_i = (i < 8);
            Req1_tag_i   = 4'($urandom_range(0, 15));
            Req1_rm_i    = 3'($urandom_range(0, 4));
            @(negedge clk);
            want = (q.size() > 0) && (q[0].due == cyc);
            vectors++;
            if (Resp_valid_o !== want) begin
                errors++;
                $display("FAIL b2b_valid cyc=%0d got=%b want=%b",
                         cyc, Resp_valid_o, want);
            end else if (want) begin
                e = q.pop_front();
                vectors++;
                if (Resp_tag_o !== e.tag) begin
                    errors++;
                    $display("FAIL b2b_tag got=%0d want=%0d", Resp_tag_o, e.tag);
                end
            end
            if (i < 8) begin
                vectors++;
                if (Req1_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept i=%0d got=%b want=1",
                             i, Req1_ready_o);
                end
                e.due = cyc + S;
                e.tag = Req1_tag_i;
                q.push_back(e);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        op_t mq[$];
        op_t o;
        op_t f;
        logic [3:0] fmodel = '0;
        logic pref = 1'b0;
        logic sel_m = 1'b0;
        logic can_acc;
        logic g0;
        logic g1;
        logic legal_hs;
        logic [2:0] r;
        apply_reset();
        for (int i = 0; i < 400 + 3 * S; i++) begin
            if (i < 400) begin
                Req0_valid_i = 1'($urandom_range(0, 1));
                Req1_valid_i = 1'($urandom_range(0, 1));
                Resp_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                Req0_valid_i = 1'b0;
                Req1_valid_i = 1'b0;
                Resp_ready_i = 1'b1;
            end
            Req0_tag_i   = 4'($urandom_range(0, 15));
            Req1_tag_i   = 4'($urandom_range(0, 15));
            Req0_rm_i    = 3'($urandom_range(0, 7));
            Req1_rm_i    = 3'($urandom_range(0, 7));
            Frm_i        = 3'($urandom_range(0, 7));
            Flags_i      = 4'($urandom_range(0, 15));
            Fflags_clr_i = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            can_acc = (mq.size() < S) || Resp_ready_i;
            g0 = 1'b0;
            g1 = 1'b0;
            if (can_acc && Req0_valid_i && Req1_valid_i) begin
`ifdef FMA_RR_ARB_EN
                g1 = pref;
                g0 = ~pref;
`else
                g0 = 1'b1;
`endif
            end else if (can_acc) begin
                g0 = Req0_valid_i;
                g1 = Req1_valid_i;
            end
            vectors++;
            if (Req0_ready_o !== g0 || Req1_ready_o !== g1 ||
                Stage_en_o[0] !== can_acc) begin
                errors++;
                $display("FAIL rnd_grant i=%0d r0=%b r1=%b en0=%b want %b %b %b",
                         i, Req0_ready_o, Req1_ready_o, Stage_en_o[0],
                         g0, g1, can_acc);
            end
            if (g0 | g1) sel_m = g1;
            vectors++;
            if (Busy_o !== (mq.size() > 0) || Src_sel_o !== sel_m) begin
                errors++;
                $display("FAIL rnd_busy_sel i=%0d busy=%b sel=%b want %b %b",
                         i, Busy_o, Src_sel_o, mq.size() > 0, sel_m);
            end
            if (mq.size() == S) begin
                vectors++;
                if (Resp_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_full_valid i=%0d got=%b want=1",
                             i, Resp_valid_o);
                end
            end
            legal_hs = 1'b0;
            if (Resp_valid_o === 1'b1) begin
                vectors++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious i=%0d got=1 want=0", i);
                end else begin
                    f = mq[0];
                    if (Resp_tag_o !== f.tag || Resp_illegal_o !== f.ill ||
                        Rounding_mode_o !== f.rm) begin
                        errors++;
                        $display("FAIL rnd_resp i=%0d tag=%0d ill=%b rm=%b want %0d %b %b",
                                 i, Resp_tag_o, Resp_illegal_o, Rounding_mode_o,
                                 f.tag, f.ill, f.rm);
                    end
                    if (Resp_ready_i) begin
                        void'(mq.pop_front());
                        legal_hs = ~f.ill;
                    end
                end
            end
            if (Fflags_clr_i)
                fmodel = legal_hs ? Flags_i : 4'b0000;
            else if (legal_hs)
                fmodel = fmodel | Flags_i;
            if (g0 | g1) begin
                r     = g1 ? Req1_rm_i : Req0_rm_i;
                o.tag = g1 ? Req1_tag_i : Req0_tag_i;
                o.rm  = (r == 3'b111) ? Frm_i : r;
                o.ill = (o.rm >= 3'd5);
                mq.push_back(o);
                pref = ~g1;
            end
            tick();
            vectors++;
            if (Fflags_o !== fmodel) begin
                errors++;
                $display("FAIL rnd_fflags i=%0d got=%b want=%b", i, Fflags_o, fmodel);
            end
        end
        idle_inputs();
        vectors++;
        if (mq.size() != 0 || Busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rnd_drain left=%0d busy=%b want 0/0", mq.size(), Busy_o);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        Resp_ready_i = 1'b1;
        Req0_rm_i = 3'b000;
        for (int i = 0; i < 2; i++) begin
            Req0_valid_i = 1'b1;
            Req0_tag_i = 4'(9 + i);
            tick();
        end
        Req0_valid_i = 1'b0;
        vectors++;
        if (Busy_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre busy=%b want=1", Busy_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if (Busy_o !== 1'b0 || Resp_valid_o !== 1'b0 || Stage_en_o !== '0) begin
            errors++;
            $display("FAIL arst_clear busy=%b rv=%b en=%b want 0",
                     Busy_o, Resp_valid_o, Stage_en_o);
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < S + 3; i++) begin
            @(negedge clk);
            vectors++;
            if (Resp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL arst_no_resp i=%0d got=%b want=0", i, Resp_valid_o);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arb();
        test_stall();
        test_rm();
        test_flags();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
